// File: rtl/pkg_en.sv
// Shared token types for the BuffEn family plus the arbiter's state encoding.
package pkg_en;

    localparam int DATA_W = 8;

    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
        logic v;
        logic c;
    } BTk_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_FLUSH} arb_state_t;

endpackage

// File: rtl/buff_en_arbiter_rr_pick.sv
// Cyclic priority encoder: first asserted request at or after I_Ptr, wrapping around.
module rr_pick #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH_REQ = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   I_Req,
    input  logic [WIDTH_REQ-1:0] I_Ptr,
    output logic                 O_Valid,
    output logic [WIDTH_REQ-1:0] O_Idx,
    output logic [NUM_REQ-1:0]   O_OneHot
);

    int                   j;
    logic [WIDTH_REQ-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is the one that sticks.
    always_comb begin
        O_Valid  = 1'b0;
        O_Idx    = '0;
        O_OneHot = '0;
        j        = 0;
        cand     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(I_Ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            cand = WIDTH_REQ'(j);
            if (I_Req[cand]) begin
                O_Valid  = 1'b1;
                O_Idx    = cand;
                O_OneHot = NUM_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/buff_en_arbiter.sv
// Round-robin, burst-granular write arbiter sharing one BuffEn among NUM_REQ producers.
module buff_en_arbiter
    import pkg_en::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16,
    parameter int WIDTH_REQ = $clog2(NUM_REQ)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     I_Req,
    input  logic [NUM_REQ-1:0]     I_Last,
    input  FTk_t [NUM_REQ-1:0]     I_FTk,
    output BTk_t [NUM_REQ-1:0]     O_BTk,
    output FTk_t                   O_FTk,
    input  BTk_t                   I_BTk,
    output logic                   O_We,
    output logic                   O_Re,
    input  logic                   I_Empty,
    input  logic                   I_Full,
    input  logic                   I_Rd_En,
    input  logic                   I_Flush,
    output logic [NUM_REQ-1:0]     O_Grant,
    output logic                   O_Busy
);

    localparam int                CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [WIDTH_REQ-1:0] IDX_LAST = WIDTH_REQ'(NUM_REQ - 1);

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [WIDTH_REQ-1:0] idx_q, idx_d;
    logic [WIDTH_REQ-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 pick_valid;
    logic [WIDTH_REQ-1:0] pick_idx;
    logic [NUM_REQ-1:0]   pick_onehot;

    logic                 in_xfer;
    FTk_t                 cur_ftk;
    logic                 wr;
    logic                 release_grant;

    rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH_REQ (WIDTH_REQ)
    ) u_pick (
        .I_Req    (I_Req),
        .I_Ptr    (ptr_q),
        .O_Valid  (pick_valid),
        .O_Idx    (pick_idx),
        .O_OneHot (pick_onehot)
    );

    // A grant ends on its last written token, on the burst cap, or when the request is withdrawn.
    always_comb begin
        in_xfer       = (state_q == ARB_XFER);
        cur_ftk       = I_FTk[idx_q];
        wr            = in_xfer & cur_ftk.v & ~I_Full & ~I_BTk.n;
        release_grant = in_xfer & ((wr & (I_Last[idx_q] | (cnt_q == CNT_LAST))) | ~I_Req[idx_q]);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (I_Flush) begin
                    state_d = ARB_FLUSH;
                end else if (pick_valid) begin
                    state_d = ARB_XFER;
                    grant_d = pick_onehot;
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_XFER: begin
                if (release_grant) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    ptr_d   = (idx_q == IDX_LAST) ? '0 : idx_q + WIDTH_REQ'(1);
                end else if (wr) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_FLUSH: begin
                if (I_Empty & ~I_Flush) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Combinational outputs that depend on raw inputs are forced quiet while reset is held.
    always_comb begin
        O_Grant = grant_q;
        O_Busy  = (state_q != ARB_IDLE);
        O_We    = wr;
        O_FTk   = in_xfer ? cur_ftk : '0;
        O_Re    = reset & ~I_Empty & (I_Rd_En | (state_q == ARB_FLUSH));
        for (int i = 0; i < NUM_REQ; i++) begin
            O_BTk[i] = '0;
            if (in_xfer && (idx_q == WIDTH_REQ'(i))) begin
                O_BTk[i]   = I_BTk;
                O_BTk[i].n = I_Full | I_BTk.n;
            end else begin
                O_BTk[i].n = I_Req[i] & reset;
            end
        end
    end

endmodule

// File: tb/tb_buff_en_arbiter.sv
// Randomised directed phases for buff_en_arbiter, checked against a grant/owner reference model.
module tb_buff_en_arbiter;
    import pkg_en::*;

    localparam int NREQ = 4;
    localparam int MAXB = 4;

    logic            clock;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] last;
    FTk_t [NREQ-1:0] ftk;
    BTk_t [NREQ-1:0] btkOut;
    FTk_t            ftkOut;
    BTk_t            btkIn;
    logic            we, re, empty, full, rdEn, flush, busy;
    logic [NREQ-1:0] grant;

    int errors = 0;
    int checks = 0;

    logic [NREQ-1:0] reqMask;
    int reqPct, validPct, lastPct, fullPct, btkNPct, emptyPct, rdEnPct, flushPct;

    bit        mHas;
    logic [1:0] mIdx;
    int        mPtr;
    int        mCount;
    bit        mFlush;
    int        dutWrites [NREQ];

    buff_en_arbiter #(
        .NUM_REQ   (NREQ),
        .MAX_BURST (MAXB)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .I_Req   (req),
        .I_Last  (last),
        .I_FTk   (ftk),
        .O_BTk   (btkOut),
        .O_FTk   (ftkOut),
        .I_BTk   (btkIn),
        .O_We    (we),
        .O_Re    (re),
        .I_Empty (empty),
        .I_Full  (full),
        .I_Rd_En (rdEn),
        .I_Flush (flush),
        .O_Grant (grant),
        .O_Busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit chance(int pct);
        return int'($urandom_range(99, 0)) < pct;
    endfunction

    task automatic setKnobs(logic [NREQ-1:0] m, int rq, int vd, int ls, int fl, int bn, int em, int rd, int fs);
        reqMask  = m;
        reqPct   = rq;
        validPct = vd;
        lastPct  = ls;
        fullPct  = fl;
        btkNPct  = bn;
        emptyPct = em;
        rdEnPct  = rd;
        flushPct = fs;
    endtask

    task automatic modelReset();
        mHas   = 1'b0;
        mIdx   = 2'd0;
        mPtr   = 0;
        mCount = 0;
        mFlush = 1'b0;
    endtask

    task automatic clearInputs();
        req   = '0;
        last  = '0;
        ftk   = '0;
        btkIn = '0;
        empty = 1'b1;
        full  = 1'b0;
        rdEn  = 1'b0;
        flush = 1'b0;
    endtask

    task automatic randomizeInputs();
        for (int i = 0; i < NREQ; i++) begin
            req[i]    = reqMask[i] & chance(reqPct);
            last[i]   = chance(lastPct);
            ftk[i].v  = chance(validPct);
            ftk[i].d  = DATA_W'($urandom);
        end
        full    = chance(fullPct);
        btkIn.n = chance(btkNPct);
        btkIn.t = 1'($urandom);
        btkIn.v = 1'($urandom);
        btkIn.c = 1'($urandom);
        empty   = chance(emptyPct);
        rdEn    = chance(rdEnPct);
        flush   = chance(flushPct);
    endtask

    task automatic compareValue(string tag, logic [63:0] observed, logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic bit modelWrite();
        return mHas && ftk[mIdx].v && !full && !btkIn.n;
    endfunction

    task automatic checkOutput();
        logic [NREQ-1:0] eGrant;
        logic            eWe, eRe, eBusy;
        FTk_t            eFtk;
        BTk_t [NREQ-1:0] eBtk;
        eGrant = '0;
        eWe    = 1'b0;
        eRe    = 1'b0;
        eBusy  = 1'b0;
        eFtk   = '0;
        eBtk   = '0;
        if (reset) begin
            eGrant = mHas ? (NREQ'(1) << mIdx) : '0;
            eBusy  = mHas || mFlush;
            eWe    = modelWrite();
            eFtk   = mHas ? ftk[mIdx] : '0;
            eRe    = !empty && (rdEn || mFlush);
            for (int i = 0; i < NREQ; i++) begin
                if (mHas && int'(mIdx) == i) begin
                    eBtk[i]   = btkIn;
                    eBtk[i].n = full | btkIn.n;
                end else begin
                    eBtk[i].n = req[i];
                end
            end
            if (we === 1'b1) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (grant[i] === 1'b1) dutWrites[i]++;
                end
            end
        end
        compareValue("grant", grant, eGrant);
        compareValue("we", we, eWe);
        compareValue("re", re, eRe);
        compareValue("busy", busy, eBusy);
        compareValue("ftk", ftkOut, eFtk);
        compareValue("btk", btkOut, eBtk);
    endtask

    // Owner keeps the buffer until its last token, its MAXB-th write, or its request drops.
    task automatic modelStep();
        bit wr;
        bit found;
        int j;
        wr = modelWrite();
        if (mHas) begin
            if (wr) mCount++;
            if ((wr && (last[mIdx] || mCount == MAXB)) || !req[mIdx]) begin
                mPtr   = (int'(mIdx) + 1) % NREQ;
                mHas   = 1'b0;
                mCount = 0;
            end
        end else if (mFlush) begin
            if (empty && !flush) mFlush = 1'b0;
        end else if (flush) begin
            mFlush = 1'b1;
        end else begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                j = (mPtr + k) % NREQ;
                if (!found && req[2'(j)]) begin
                    found  = 1'b1;
                    mHas   = 1'b1;
                    mIdx   = 2'(j);
                    mCount = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(int cycles);
        repeat (cycles) begin
            @(negedge clock);
            randomizeInputs();
            #1;
            checkOutput();
            if (reset) modelStep();
        end
    endtask

    initial begin
        bit found;
        int lo, hi;
        modelReset();
        clearInputs();
        reset = 1'b0;
        setKnobs(4'b1111, 100, 100, 0, 0, 0, 0, 100, 0);
        randomizeInputs();
        #1;
        checkOutput();
        clearInputs();
        @(negedge clock);
        reset = 1'b1;

        $display("[TB] single requester");
        setKnobs(4'b0001, 100, 100, 33, 0, 0, 50, 50, 0);
        applyStimulus(30);

        $display("[TB] fairness");
        for (int i = 0; i < NREQ; i++) dutWrites[i] = 0;
        setKnobs(4'b1111, 100, 100, 100, 0, 0, 50, 50, 0);
        applyStimulus(40);
        lo = dutWrites[0];
        hi = dutWrites[0];
        for (int i = 1; i < NREQ; i++) begin
            if (dutWrites[i] < lo) lo = dutWrites[i];
            if (dutWrites[i] > hi) hi = dutWrites[i];
        end
        compareValue("fairSpread", 64'(hi - lo <= 1), 64'd1);
        compareValue("fairActive", 64'(lo > 0), 64'd1);

        $display("[TB] burst cap");
        setKnobs(4'b0100, 100, 100, 0, 0, 0, 50, 50, 0);
        applyStimulus(40);

        $display("[TB] buffer full");
        setKnobs(4'b0001, 100, 90, 10, 60, 10, 20, 0, 0);
        applyStimulus(60);
        setKnobs(4'b0001, 100, 90, 10, 10, 10, 20, 100, 0);
        applyStimulus(30);

        $display("[TB] flush");
        setKnobs(4'b1111, 90, 80, 20, 10, 10, 30, 50, 15);
        applyStimulus(200);

        $display("[TB] reset mid-transfer");
        setKnobs(4'b1111, 100, 100, 0, 0, 0, 50, 50, 0);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            applyStimulus(1);
            found = mHas;
        end
        if (!found) begin
            checks++;
            errors++;
            $error("[TB] FAIL grantWait observed=no grant expected=grant within 50 cycles");
        end
        @(posedge clock);
        #1;
        checkOutput();
        #1;
        reset = 1'b0;
        #1;
        checkOutput();
        modelReset();
        clearInputs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(20);

        $display("[TB] random traffic");
        setKnobs(4'b1111, 70, 70, 25, 20, 15, 50, 50, 3);
        applyStimulus(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
